reg_file_scoreboard: RTL

Architectural register file and write-port endpoint for the LC3 pipeline. It consumes the writeback stage's selected result (`DR_in`) and destination, holds R0-R7 and the NZP condition codes, and serves two read ports to decode/execute with same-cycle write-through bypass. A per-register pending scoreboard is set at issue and cleared at writeback. From it the block drives a stall request whenever an issuing instruction reads a register whose result has not yet been written.

---
 rtl/reg_file_scoreboard.sv | 104 ++++++++++
 1 files changed

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
// Architectural register file (R0..R7), NZP condition codes and a
// per-register pending scoreboard for the LC3 pipeline.
//
// Ports
//   clock               sole clock, rising edge
//   reset               synchronous active-low reset
//   wb_en, dr, DR_in    writeback write port
//   cc_en               update NZP from DR_in (qualified by wb_en)
//   sr1, sr2            read addresses
//   sr1_use, sr2_use    issuing instruction really reads that source
//   issue_en, issue_dr  instruction with a destination issues this cycle
//   VSR1, VSR2          combinational read data with writeback bypass
//   psr                 registered NZP as {N,Z,P}
//   stall               combinational read-after-write hazard request
//   pending             registered scoreboard, bit i = Ri awaiting writeback
module reg_file_scoreboard #(
   parameter int DW   = 16,
   parameter int NREG = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    wb_en,
   input  logic [$clog2(NREG)-1:0] dr,
   input  logic [DW-1:0]           DR_in,
   input  logic                    cc_en,
   input  logic [$clog2(NREG)-1:0] sr1,
   input  logic [$clog2(NREG)-1:0] sr2,
   input  logic                    sr1_use,
   input  logic                    sr2_use,
   input  logic                    issue_en,
   input  logic [$clog2(NREG)-1:0] issue_dr,
   output logic [DW-1:0]           VSR1,
   output logic [DW-1:0]           VSR2,
   output logic [2:0]              psr,
   output logic                    stall,
   output logic [NREG-1:0]         pending
);

   logic [DW-1:0]   regs [NREG];
   logic [NREG-1:0] pending_nxt;
   logic [2:0]      nzp_nxt;
   logic            wr_hit1;
   logic            wr_hit2;
   logic            hz1;
   logic            hz2;

   // Register array and condition codes
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
         psr <= 3'b010;
      end else if (wb_en) begin
         regs[dr] <= DR_in;
         if (cc_en) begin
            psr <= nzp_nxt;
         end
      end
   end

   always_comb begin
      nzp_nxt = 3'b001;
      if (DR_in[DW-1]) begin
         nzp_nxt = 3'b100;
      end else if (DR_in == '0) begin
         nzp_nxt = 3'b010;
      end
   end

   // Clear first, then set: when both hit the same register the newer
   // producer is still outstanding, so the set must win.
   always_comb begin
      pending_nxt = pending;
      if (wb_en) begin
         pending_nxt[dr] = 1'b0;
      end
      if (issue_en) begin
         pending_nxt[issue_dr] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

   // Same-cycle write-through bypass, independent of sr*_use
   assign wr_hit1 = wb_en && (dr == sr1);
   assign wr_hit2 = wb_en && (dr == sr2);

   assign VSR1 = wr_hit1 ? DR_in : regs[sr1];
   assign VSR2 = wr_hit2 ? DR_in : regs[sr2];

   // A source being written this cycle is covered by the bypass
   assign hz1   = sr1_use && pending[sr1] && !wr_hit1;
   assign hz2   = sr2_use && pending[sr2] && !wr_hit2;
   assign stall = hz1 || hz2;

endmodule
